// File: rtl/fib_arb_pkg.sv
// Shared types and constants for the FIB arbiter: FSM state encoding,
// FIB operation codes and default key widths.
package fib_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic FIB_OP_LOOKUP = 1'b0;
    localparam logic FIB_OP_INSERT = 1'b1;

    localparam int PREFIX_W_DEF = 64;
    localparam int LEN_W_DEF    = 6;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, priority pointer
// that moves to the other requester whenever update_i accepts a grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o,
    output logic       ptr_o
);

    // ptr_q names the requester that wins a tie (0 = requester 0).
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update_i && gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (update_i && gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fib_arbiter.sv
// Arbitrates PIT lookups and data-side inserts onto a single FIB port.
// Define FIB_ARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles.
module fib_arbiter
    import fib_arb_pkg::*;
#(
    parameter int PREFIX_W = PREFIX_W_DEF,
    parameter int LEN_W    = LEN_W_DEF,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pit_req,
    input  logic [PREFIX_W-1:0] pit_prefix,
    input  logic [LEN_W-1:0]    pit_len,
    output logic                pit_gnt,
    output logic                pit_done,
    output logic                pit_hit,
    input  logic                dat_req,
    input  logic [PREFIX_W-1:0] dat_prefix,
    input  logic [LEN_W-1:0]    dat_len,
    output logic                dat_gnt,
    output logic                dat_done,
    output logic                dat_ok,
    output logic                fib_start,
    output logic                fib_op,
    output logic [PREFIX_W-1:0] fib_prefix,
    output logic [LEN_W-1:0]    fib_len,
    input  logic                fib_ack,
    input  logic                fib_hit,
    input  logic                fib_rejected,
    output logic                err_timeout
);

    state_e              state_q;
    logic                pit_gnt_q, dat_gnt_q, fib_start_q;
    logic                pit_done_q, dat_done_q, pit_hit_q, dat_ok_q;
    logic                fib_op_q;
    logic [PREFIX_W-1:0] fib_prefix_q;
    logic [LEN_W-1:0]    fib_len_q;

    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    logic       arb_update;
    logic       arb_ptr_unused;

    assign arb_req    = {dat_req, pit_req};
    assign arb_update = (state_q == ST_IDLE) && (arb_gnt != 2'b00);

    rr_arb2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .req_i    (arb_req),
        .update_i (arb_update),
        .gnt_o    (arb_gnt),
        .ptr_o    (arb_ptr_unused)
    );

`ifdef FIB_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    logic [7:0] wait_cnt_q;
    logic       err_timeout_q;
`else
    localparam logic [7:0] timeout_unused = 8'(TIMEOUT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pit_gnt_q    <= 1'b0;
            dat_gnt_q    <= 1'b0;
            fib_start_q  <= 1'b0;
            pit_done_q   <= 1'b0;
            dat_done_q   <= 1'b0;
            pit_hit_q    <= 1'b0;
            dat_ok_q     <= 1'b0;
            fib_op_q     <= FIB_OP_LOOKUP;
            fib_prefix_q <= '0;
            fib_len_q    <= '0;
`ifdef FIB_ARB_TIMEOUT_EN
            wait_cnt_q    <= 8'd0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            // Every pulse output defaults low; states below raise them for one cycle.
            pit_gnt_q   <= 1'b0;
            dat_gnt_q   <= 1'b0;
            fib_start_q <= 1'b0;
            pit_done_q  <= 1'b0;
            dat_done_q  <= 1'b0;
            pit_hit_q   <= 1'b0;
            dat_ok_q    <= 1'b0;
`ifdef FIB_ARB_TIMEOUT_EN
            err_timeout_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (arb_gnt != 2'b00) begin
                        fib_op_q     <= arb_gnt[1] ? FIB_OP_INSERT : FIB_OP_LOOKUP;
                        fib_prefix_q <= arb_gnt[1] ? dat_prefix : pit_prefix;
                        fib_len_q    <= arb_gnt[1] ? dat_len : pit_len;
                        pit_gnt_q    <= arb_gnt[0];
                        dat_gnt_q    <= arb_gnt[1];
                        fib_start_q  <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef FIB_ARB_TIMEOUT_EN
                    wait_cnt_q <= 8'd0;
`endif
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fib_ack) begin
                        state_q <= ST_DONE;
                        if (fib_op_q == FIB_OP_INSERT) begin
                            dat_done_q <= 1'b1;
                            dat_ok_q   <= ~fib_rejected;
                        end else begin
                            pit_done_q <= 1'b1;
                            pit_hit_q  <= fib_hit;
                        end
                    end
`ifdef FIB_ARB_TIMEOUT_EN
                    else if (wait_cnt_q == TIMEOUT_CNT) begin
                        state_q       <= ST_DONE;
                        err_timeout_q <= 1'b1;
                        dat_done_q    <= (fib_op_q == FIB_OP_INSERT);
                        pit_done_q    <= (fib_op_q == FIB_OP_LOOKUP);
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
`endif
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pit_gnt    = pit_gnt_q;
    assign dat_gnt    = dat_gnt_q;
    assign fib_start  = fib_start_q;
    assign pit_done   = pit_done_q;
    assign dat_done   = dat_done_q;
    assign pit_hit    = pit_hit_q;
    assign dat_ok     = dat_ok_q;
    assign fib_op     = fib_op_q;
    assign fib_prefix = fib_prefix_q;
    assign fib_len    = fib_len_q;
`ifdef FIB_ARB_TIMEOUT_EN
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fib_arbiter.sv
// Directed bench for fib_arbiter: a vector table of single operations plus
// hand-written sequences for round-robin, withdrawal, reset and timeout.
module tb_fib_arbiter;

    localparam int PW = 64;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          pit_req, dat_req;
    logic [PW-1:0] pit_prefix, dat_prefix;
    logic [LW-1:0] pit_len, dat_len;
    logic          pit_gnt, pit_done, pit_hit;
    logic          dat_gnt, dat_done, dat_ok;
    logic          fib_start, fib_op;
    logic [PW-1:0] fib_prefix;
    logic [LW-1:0] fib_len;
    logic          fib_ack, fib_hit, fib_rejected;
    logic          err_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fib_arbiter #(.PREFIX_W(PW), .LEN_W(LW), .TIMEOUT(10)) dut (
        .clk(clk), .rst(rst),
        .pit_req(pit_req), .pit_prefix(pit_prefix), .pit_len(pit_len),
        .pit_gnt(pit_gnt), .pit_done(pit_done), .pit_hit(pit_hit),
        .dat_req(dat_req), .dat_prefix(dat_prefix), .dat_len(dat_len),
        .dat_gnt(dat_gnt), .dat_done(dat_done), .dat_ok(dat_ok),
        .fib_start(fib_start), .fib_op(fib_op), .fib_prefix(fib_prefix), .fib_len(fib_len),
        .fib_ack(fib_ack), .fib_hit(fib_hit), .fib_rejected(fib_rejected),
        .err_timeout(err_timeout)
    );

    typedef struct {
        logic          is_dat;
        logic [PW-1:0] prefix;
        logic [LW-1:0] len;
        int            ack_dly;
        logic          hit;
        logic          rej;
        logic          exp_res;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_any_gnt(output int cyc, output logic got_dat, output logic ok);
        cyc = 0;
        got_dat = 1'b0;
        ok = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (pit_gnt || dat_gnt) begin
                cyc = i;
                got_dat = dat_gnt;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int   cyc;
        logic gd, ok, early;
        @(negedge clk);
        if (v.is_dat) begin
            dat_req = 1'b1; dat_prefix = v.prefix; dat_len = v.len;
        end else begin
            pit_req = 1'b1; pit_prefix = v.prefix; pit_len = v.len;
        end
        wait_any_gnt(cyc, gd, ok);
        pit_req = 1'b0;
        dat_req = 1'b0;
        chk({tag, "_gnt_seen"}, 64'(ok), 64'd1);
        if (!ok) return;
        chk({tag, "_gnt_lat"}, 64'(cyc), 64'd1);
        chk({tag, "_gnt_side"}, 64'(gd), 64'(v.is_dat));
        chk({tag, "_start"}, 64'(fib_start), 64'd1);
        chk({tag, "_op"}, 64'(fib_op), 64'(v.is_dat));
        chk({tag, "_prefix"}, fib_prefix, v.prefix);
        chk({tag, "_len"}, 64'(fib_len), 64'(v.len));
        early = 1'b0;
        for (int i = 0; i < v.ack_dly; i++) begin
            @(negedge clk);
            early = early | pit_done | dat_done | fib_start;
        end
        chk({tag, "_no_early_done"}, 64'(early), 64'd0);
        fib_ack = 1'b1; fib_hit = v.hit; fib_rejected = v.rej;
        @(negedge clk);
        fib_ack = 1'b0; fib_hit = 1'b0; fib_rejected = 1'b0;
        chk({tag, "_done"}, 64'({pit_done, dat_done}), v.is_dat ? 64'd1 : 64'd2);
        chk({tag, "_result"}, 64'({pit_hit, dat_ok}),
            v.is_dat ? 64'({1'b0, v.exp_res}) : 64'({v.exp_res, 1'b0}));
        chk({tag, "_err_to"}, 64'(err_timeout), 64'd0);
        chk({tag, "_prefix_hold"}, fib_prefix, v.prefix);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'({pit_done, dat_done, pit_hit, dat_ok}), 64'd0);
        $display("op %s: dat=%0d prefix=%h len=%0d result=%0d", tag, v.is_dat, v.prefix, v.len, v.exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic gd, ok, seen;
        vec_t v;

        vecs[0] = '{1'b0, 64'hDEAD_BEEF_0000_0001, 6'd32, 3, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 64'h0123_4567_89AB_CDEF, 6'd16, 2, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 64'h0000_0000_0000_0000, 6'd0,  5, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 64'hA5A5_5A5A_0F0F_F0F0, 6'd48, 1, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        pit_req = 1'b0; dat_req = 1'b0;
        pit_prefix = '0; dat_prefix = '0; pit_len = '0; dat_len = '0;
        fib_ack = 1'b0; fib_hit = 1'b0; fib_rejected = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({pit_gnt, pit_done, pit_hit, dat_gnt, dat_done, dat_ok,
                               fib_start, fib_op, err_timeout}), 64'd0);
        chk("reset_key", fib_prefix ^ 64'(fib_len), 64'd0);
        rst = 1'b0;
        $display("reset: outputs checked");

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Both requesters held from reset release: grants must alternate.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pit_req = 1'b1; pit_prefix = 64'h1111_0000_0000_0001; pit_len = 6'd8;
        dat_req = 1'b1; dat_prefix = 64'h2222_0000_0000_0002; dat_len = 6'd24;
        for (int k = 0; k < 4; k++) begin
            wait_any_gnt(cyc, gd, ok);
            chk("rr_gnt_seen", 64'(ok), 64'd1);
            if (!ok) break;
            chk("rr_winner", 64'(gd), 64'(k % 2));
            chk("rr_spacing", 64'(cyc), (k == 0) ? 64'd1 : 64'd2);
            chk("rr_prefix", fib_prefix, gd ? 64'h2222_0000_0000_0002 : 64'h1111_0000_0000_0001);
            @(negedge clk);
            fib_ack = 1'b1; fib_hit = 1'b1; fib_rejected = 1'b0;
            @(negedge clk);
            fib_ack = 1'b0; fib_hit = 1'b0;
            chk("rr_done", 64'({pit_done, dat_done}), gd ? 64'd1 : 64'd2);
            $display("rr op %0d: winner=%s", k, gd ? "DAT" : "PIT");
        end
        pit_req = 1'b0; dat_req = 1'b0;
        repeat (2) @(negedge clk);

        // A request pulsed low before the sampling edge and an ack in IDLE.
        pit_req = 1'b1;
        #2 pit_req = 1'b0;
        fib_ack = 1'b1; fib_hit = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen = seen | pit_gnt | dat_gnt | fib_start | pit_done | dat_done;
        end
        fib_ack = 1'b0; fib_hit = 1'b0;
        chk("withdraw_idle_ack", 64'(seen), 64'd0);
        $display("withdraw: no grant, idle ack ignored");

        // Reset in WAIT aborts the operation; a following ack is ignored.
        @(negedge clk);
        pit_req = 1'b1; pit_prefix = 64'hCAFE_0000_0000_0099; pit_len = 6'd40;
        wait_any_gnt(cyc, gd, ok);
        pit_req = 1'b0;
        chk("rstwait_gnt_seen", 64'(ok), 64'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rstwait_ctrl", 64'({pit_gnt, pit_done, pit_hit, dat_gnt, dat_done, dat_ok,
                                 fib_start, fib_op, err_timeout}), 64'd0);
        chk("rstwait_prefix", fib_prefix, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        fib_ack = 1'b1; fib_hit = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | pit_done | dat_done | pit_hit;
        end
        fib_ack = 1'b0; fib_hit = 1'b0;
        chk("rstwait_no_done", 64'(seen), 64'd0);
        $display("reset in wait: aborted");
        v = '{1'b0, 64'h0BAD_F00D_0000_0042, 6'd20, 2, 1'b1, 1'b0, 1'b1};
        run_op(v, "after_rst");

        // Long-running WAIT: aborted by timeout when enabled, otherwise held.
        @(negedge clk);
        pit_req = 1'b1; pit_prefix = 64'h7777_0000_0000_0007; pit_len = 6'd12;
        wait_any_gnt(cyc, gd, ok);
        pit_req = 1'b0;
        chk("long_gnt_seen", 64'(ok), 64'd1);
`ifdef FIB_ARB_TIMEOUT_EN
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (pit_done) begin
                cyc = i;
                break;
            end
        end
        chk("to_latency", 64'(cyc), 64'd12);
        chk("to_err", 64'(err_timeout), 64'd1);
        chk("to_result", 64'({pit_hit, dat_done}), 64'd0);
        @(negedge clk);
        fib_ack = 1'b1; fib_hit = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | pit_done | pit_hit | err_timeout;
        end
        fib_ack = 1'b0; fib_hit = 1'b0;
        chk("to_late_ack", 64'(seen), 64'd0);
        $display("timeout: done after %0d cycles from grant", cyc);
`else
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen = seen | pit_done | err_timeout;
        end
        chk("nto_hold", 64'(seen), 64'd0);
        fib_ack = 1'b1; fib_hit = 1'b1;
        @(negedge clk);
        fib_ack = 1'b0; fib_hit = 1'b0;
        chk("nto_done", 64'({pit_done, pit_hit, err_timeout}), 64'b110);
        $display("no timeout: waited 20 cycles then acked");
`endif
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fib_arbiter.md
FIB_ARBITER -- requirements
Module: fib_arbiter

Interface
REQ-001 SHALL have parameter PREFIX_W, default 64, prefix width in bits.
REQ-002 SHALL have parameter LEN_W, default 6, prefix length field width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max WAIT cycles, 1..255.
REQ-004 SHALL have port clk  in  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port pit_req  in  1  PIT lookup request, held until pit_gnt.
REQ-007 SHALL have ports pit_prefix / pit_len  in  PREFIX_W / LEN_W  lookup key.
REQ-008 SHALL have ports pit_gnt, pit_done, pit_hit  out  1 each  grant pulse, completion pulse, lookup result.
REQ-009 SHALL have port dat_req  in  1  data-side insert request, held until dat_gnt.
REQ-010 SHALL have ports dat_prefix / dat_len  in  PREFIX_W / LEN_W  insert key.
REQ-011 SHALL have ports dat_gnt, dat_done, dat_ok  out  1 each  grant pulse, completion pulse, insert accepted.
REQ-012 SHALL have ports fib_start  out  1 (op start pulse), fib_op  out  1 (0 lookup, 1 insert), fib_prefix  out  PREFIX_W, fib_len  out  LEN_W.
REQ-013 SHALL have ports fib_ack, fib_hit, fib_rejected  in  1 each  FIB completion, lookup hit, insert rejected.
REQ-014 SHALL have port err_timeout  out  1  pulse with done when FIB failed to ack.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE, one cycle each except WAIT.
REQ-016 IDLE: any req high SHALL select a winner, latch its prefix/len/op, go ISSUE next cycle.
REQ-017 ISSUE: fib_start=1 and winner's gnt=1 for exactly one cycle; then WAIT.
REQ-018 fib_op/fib_prefix/fib_len SHALL be registered and stable from ISSUE until return to IDLE.
REQ-019 WAIT: fib_ack=1 SHALL capture fib_hit (PIT) or !fib_rejected (data) and go DONE.
REQ-020 DONE: winner's done=1 one cycle with its result bit valid same cycle; loser's outputs 0.
REQ-021 Latency: req sampled at edge N -> gnt/fib_start at N+1; ack at edge M -> done at M+1.
REQ-022 Both reqs high in IDLE: round-robin; winner is the requester not served last.
REQ-023 Single req SHALL win regardless of round-robin pointer.
REQ-024 fib_ack outside WAIT SHALL be ignored (includes late ack after timeout).
REQ-025 req dropped before gnt SHALL be treated as withdrawn; no grant issued if low in IDLE.
REQ-026 Back-to-back: req held in DONE SHALL be arbitrated in the following IDLE cycle (4-cycle min spacing + FIB latency).

Reset
REQ-027 rst high SHALL force IDLE immediately; all outputs 0; round-robin pointer = PIT first; timeout counter 0.
REQ-028 rst mid-operation SHALL abort without done pulse; subsequent ack ignored.

Configuration
REQ-029 With FIB_ARB_TIMEOUT_EN defined: 8-bit counter clears on WAIT entry; at TIMEOUT cycles without ack go DONE, result bits 0, err_timeout=1 with done.
REQ-030 Without FIB_ARB_TIMEOUT_EN: WAIT indefinitely; err_timeout tied 0; no counter logic.

Structure
REQ-031 Package fib_arb_pkg SHALL hold state enum, FIB_OP_LOOKUP/FIB_OP_INSERT constants, PREFIX_W/LEN_W defaults.
REQ-032 Sub-module rr_arb2 SHALL implement 2-way round-robin (req[1:0], update strobe, gnt[1:0], pointer).

Verification
REQ-033 PIT req prefix 0xDEAD_BEEF_0000_0001 len 32, ack 3 cycles after start with hit=1 -> gnt at N+1, fib_op=0, pit_done one cycle after ack, pit_hit=1.
REQ-034 dat_req len 16, ack with rejected=1 -> fib_op=1, dat_done pulse, dat_ok=0.
REQ-035 Both reqs held from reset release -> grants alternate PIT, DATA, PIT, DATA across 4 ops.
REQ-036 Timeout build TIMEOUT=10, no ack -> done 11 cycles after WAIT entry, err_timeout=1, result 0; late ack ignored.
REQ-037 rst asserted in WAIT -> immediate IDLE, outputs 0, no done; next PIT req served normally.
